fpm_arbiter: RTL and testbench

FPM_ARBITER -- requirements
Module: fpm_arbiter

---
 rtl/fpm_arbiter.sv | 139 +++++++++++++
 tb/tb_fpm_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpm_arbiter.sv
// Shares one external floating-point multiplier among NREQ requesters.
// Fixed-priority grant by default; define FPM_ARB_RR_EN for round-robin arbitration.
module fpm_arbiter #(
   parameter int unsigned NREQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_in1,
   input  logic [32*NREQ-1:0]   req_in2,
   input  logic [NREQ-1:0]      req_add1,
   input  logic [NREQ-1:0]      req_add2,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_data,
   output logic                 rsp_add,
   output logic [31:0]          mul_in1,
   output logic [31:0]          mul_in2,
   output logic                 mul_add1,
   output logic                 mul_add2,
   input  logic [31:0]          mul_out,
   input  logic                 mul_addout,
   output logic                 busy
);

   localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_gid;
   logic [31:0]     r_in1;
   logic [31:0]     r_in2;
   logic            r_add1;
   logic            r_add2;
   logic [31:0]     r_res;
   logic            r_res_add;

   logic [NREQ-1:0] w_gnt_oh;
   logic [GW-1:0]   w_gid;
   logic [31:0]     w_sel_in1;
   logic [31:0]     w_sel_in2;
   logic            w_sel_add1;
   logic            w_sel_add2;
   logic            w_fire;
   logic            w_rsp_take;

`ifdef FPM_ARB_RR_EN
   logic [GW-1:0]   r_ptr;
   logic [NREQ-1:0] w_rot;
   logic [NREQ-1:0] w_low;

   // Rotate requests so the pointer lane sits at bit 0, take the lowest, rotate back.
   assign w_rot    = NREQ'({req_valid, req_valid} >> r_ptr);
   assign w_low    = w_rot & (~w_rot + ONE);
   assign w_gnt_oh = NREQ'(({w_low, w_low} << r_ptr) >> NREQ);
`else
   assign w_gnt_oh = req_valid & (~req_valid + ONE);
`endif

   assign w_sel_add1 = |(req_add1 & w_gnt_oh);
   assign w_sel_add2 = |(req_add2 & w_gnt_oh);

   // One-hot grant to index and operand mux.
   always_comb begin
      w_gid     = '0;
      w_sel_in1 = '0;
      w_sel_in2 = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (w_gnt_oh == (ONE << k)) begin
            w_gid     = GW'(k);
            w_sel_in1 = req_in1[32*k +: 32];
            w_sel_in2 = req_in2[32*k +: 32];
         end
      end
   end

   // req_ready is the only combinational output; reset gates it immediately.
   assign req_ready  = (r_state == S_IDLE && !rst) ? w_gnt_oh : '0;
   assign w_fire     = |(req_valid & req_ready);
   assign w_rsp_take = |(rsp_ready & (ONE << r_gid));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_gid     <= '0;
         r_in1     <= '0;
         r_in2     <= '0;
         r_add1    <= 1'b0;
         r_add2    <= 1'b0;
         r_res     <= '0;
         r_res_add <= 1'b0;
`ifdef FPM_ARB_RR_EN
         r_ptr     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fire) begin
                  r_in1   <= w_sel_in1;
                  r_in2   <= w_sel_in2;
                  r_add1  <= w_sel_add1;
                  r_add2  <= w_sel_add2;
                  r_gid   <= w_gid;
`ifdef FPM_ARB_RR_EN
                  r_ptr   <= (w_gid == GW'(NREQ - 1)) ? '0 : w_gid + GW'(1);
`endif
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_res     <= mul_out;
               r_res_add <= mul_addout;
               r_state   <= S_RESP;
            end
            S_RESP: begin
               if (w_rsp_take) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mul_in1   = r_in1;
   assign mul_in2   = r_in2;
   assign mul_add1  = r_add1;
   assign mul_add2  = r_add2;
   assign rsp_data  = r_res;
   assign rsp_add   = r_res_add;
   assign rsp_valid = (r_state == S_RESP) ? (ONE << r_gid) : '0;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpm_arbiter.sv
// Bench for fpm_arbiter: transaction-level reference model plus a behavioural fpm.
module tb_fpm_arbiter;

   localparam int N = 4;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [32*N-1:0] req_in1;
   logic [32*N-1:0] req_in2;
   logic [N-1:0]    req_add1;
   logic [N-1:0]    req_add2;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [31:0]     rsp_data;
   logic            rsp_add;
   logic [31:0]     mul_in1;
   logic [31:0]     mul_in2;
   logic            mul_add1;
   logic            mul_add2;
   logic [31:0]     mul_out;
   logic            mul_addout;
   logic            busy;

   int errors = 0;
   int checks = 0;
   int m_ptr  = 0;

   fpm_arbiter #(.NREQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_in1(req_in1), .req_in2(req_in2),
      .req_add1(req_add1), .req_add2(req_add2),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_add(rsp_add),
      .mul_in1(mul_in1), .mul_in2(mul_in2),
      .mul_add1(mul_add1), .mul_add2(mul_add2),
      .mul_out(mul_out), .mul_addout(mul_addout),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple truncating single-precision multiply; a zero hidden bit yields zero.
   function automatic logic [32:0] fpm_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic aa, input logic ab);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] m;
      if (!aa || !ab) return 33'd0;
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 10'd1;
      end else begin
         m = p[45:23];
      end
      return {1'b1, a[31] ^ b[31], e[7:0], m};
   endfunction

   always_comb {mul_addout, mul_out} = fpm_f(mul_in1, mul_in2, mul_add1, mul_add2);

   function automatic logic [N-1:0] oh(input int i);
      logic [N-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   // Grant rule: first asserted lane searching upward from the pointer.
   function automatic int pick(input logic [N-1:0] m, input int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (m[i]) return i;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_ops();
      for (int i = 0; i < N; i++) begin
         req_in1[32*i +: 32] = $urandom;
         req_in2[32*i +: 32] = $urandom;
         req_add1[i] = ($urandom % 4) != 0;
         req_add2[i] = ($urandom % 4) != 0;
      end
   endtask

   // One full transaction from IDLE; checks grant, EXEC, RESP hold and release.
   task automatic run_txn(input logic [N-1:0] mask, input int hold, input bit keep,
                          input string tag, output int gnt, output logic [32:0] got);
      int g;
      logic [31:0] a, b;
      logic aa, ab;
      logic [32:0] er;
      req_valid = mask;
      #1;
      g  = pick(mask, m_ptr);
      a  = req_in1[32*g +: 32];
      b  = req_in2[32*g +: 32];
      aa = req_add1[g];
      ab = req_add2[g];
      er = fpm_f(a, b, aa, ab);
      checks++;
      if (req_ready !== oh(g)) begin
         errors++;
         $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, oh(g));
      end
      tick();
`ifdef FPM_ARB_RR_EN
      m_ptr = (g + 1) % N;
`endif
      if (!keep) req_valid[g] = 1'b0;
      rsp_ready = '1;
      #1;
      checks++;
      if (busy !== 1'b1 || req_ready !== '0 || rsp_valid !== '0 || mul_in1 !== a ||
          mul_in2 !== b || mul_add1 !== aa || mul_add2 !== ab) begin
         errors++;
         $display("FAIL %s exec: busy=%b req_ready=%b rsp_valid=%b mul_in1=%h mul_in2=%h expected busy=1 0 0 %h %h",
                  tag, busy, req_ready, rsp_valid, mul_in1, mul_in2, a, b);
      end
      tick();
      for (int h = 0; h <= hold; h++) begin
         checks++;
         if (rsp_valid !== oh(g) || {rsp_add, rsp_data} !== er || req_ready !== '0 ||
             busy !== 1'b1) begin
            errors++;
            $display("FAIL %s resp[%0d]: rsp_valid=%b data=%h add=%b req_ready=%b busy=%b expected %b %h %b 0 1",
                     tag, h, rsp_valid, rsp_data, rsp_add, req_ready, busy, oh(g), er[31:0], er[32]);
         end
         if (h < hold) begin
            rsp_ready = ~oh(g) & ((h % 2 == 0) ? '1 : N'($urandom));
            tick();
         end
      end
      got = {rsp_add, rsp_data};
      rsp_ready = oh(g);
      tick();
      rsp_ready = '0;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== '0) begin
         errors++;
         $display("FAIL %s release: busy=%b rsp_valid=%b expected 0 0", tag, busy, rsp_valid);
      end
      gnt = g;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '1;
      #1;
      checks++;
      if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || mul_in1 !== '0 ||
          mul_add1 !== 1'b0 || rsp_data !== '0 || rsp_add !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy=%b req_ready=%b rsp_valid=%b mul_in1=%h rsp_data=%h expected all 0",
                  busy, req_ready, rsp_valid, mul_in1, rsp_data);
      end
      req_valid = '0;
      tick();
      rst = 1'b0;
      m_ptr = 0;
      tick();
      checks++;
      if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== '0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b rsp_valid=%b req_ready=%b expected 0", busy, rsp_valid, req_ready);
      end
   endtask

   task automatic test_basic();
      int g;
      logic [32:0] got;
      randomize_ops();
      req_in1[31:0] = 32'h4000_0000;
      req_in2[31:0] = 32'h4040_0000;
      req_add1[0] = 1'b1;
      req_add2[0] = 1'b1;
      run_txn(4'b0001, 0, 1'b0, "basic", g, got);
      checks++;
      if (got !== {1'b1, 32'h40C0_0000}) begin
         errors++;
         $display("FAIL basic_product: got add=%b data=%h expected 1 40c00000", got[32], got[31:0]);
      end
   endtask

   task automatic test_order();
      int g, e;
      logic [32:0] got;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_ptr = 0;
      randomize_ops();
      for (int i = 0; i < 5; i++) begin
         run_txn(4'b1111, 0, 1'b1, "order", g, got);
`ifdef FPM_ARB_RR_EN
         e = i % N;
`else
         e = 0;
`endif
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL order[%0d]: grant=%0d expected %0d", i, g, e);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_hold();
      int g;
      logic [32:0] got;
      randomize_ops();
      run_txn(4'b0001, 5, 1'b0, "hold", g, got);
   endtask

   task automatic test_passthru();
      int g;
      logic [32:0] got;
      randomize_ops();
      req_add1[1] = 1'b0;
      run_txn(4'b0010, 2, 1'b0, "passthru", g, got);
      checks++;
      if (got !== 33'd0) begin
         errors++;
         $display("FAIL passthru_zero: got %h expected 0", got);
      end
   endtask

   task automatic test_idle();
      req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         rsp_ready = N'($urandom);
         tick();
         checks++;
         if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== '0) begin
            errors++;
            $display("FAIL idle[%0d]: busy=%b req_ready=%b rsp_valid=%b expected 0", i, busy, req_ready, rsp_valid);
         end
      end
      rsp_ready = '0;
   endtask

   task automatic test_reset_mid();
      int g;
      logic [32:0] got;
      randomize_ops();
      req_valid = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL rstmid_grant: req_ready=%b expected 0100", req_ready);
      end
      tick();
      rsp_ready = '1;
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || mul_in1 !== '0 ||
          rsp_data !== '0 || rsp_add !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_clear: busy=%b req_ready=%b rsp_valid=%b mul_in1=%h rsp_data=%h expected all 0",
                  busy, req_ready, rsp_valid, mul_in1, rsp_data);
      end
      tick();
      rst = 1'b0;
      m_ptr = 0;
      req_valid = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_nores[%0d]: rsp_valid=%b busy=%b expected 0", i, rsp_valid, busy);
         end
      end
      rsp_ready = '0;
      run_txn(4'b1010, 1, 1'b0, "rstmid_next", g, got);
   endtask

   task automatic test_random();
      int g;
      logic [32:0] got;
      logic [N-1:0] mask;
      for (int i = 0; i < 40; i++) begin
         randomize_ops();
         mask = N'($urandom);
         if (mask == '0) mask = oh($urandom_range(N - 1));
         run_txn(mask, $urandom_range(3), 1'($urandom), "random", g, got);
      end
      req_valid = '0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_in1   = '0;
      req_in2   = '0;
      req_add1  = '0;
      req_add2  = '0;
      test_reset();
      test_basic();
      test_order();
      test_hold();
      test_passthru();
      test_idle();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
